fir_stream_sequencer: RTL and testbench
=======================================

// Module: fir_stream_sequencer
// PURPOSE
//  Sequences one fir_convolution instance through a frame: loads LENGTH coefficients from a banked
//  coefficient RAM, then streams FRAME_LEN samples through it with valid/ready handshakes.
//  Asserts the stop flag on the last sample and returns the filter to idle.
//  Sits between the sample source/sink and the filter datapath; sole owner of the filter's control flags.
// PARAMETERS
//  LENGTH      20  filter taps; coefficients per bank
//  DATA_WIDTH  18  sample/coefficient width (signed)
//  BANKS       2   coefficient banks in RAM; RAM address = bank*LENGTH + tap
//  CNT_WIDTH   16  width of frame_len / sample counter
//  RESULT_LAT  1   cycles from a load_data_flag pulse to a valid result on fir_result
// PORTS
//  clock               in   1                 rising-edge clock
//  reset_n             in   1                 synchronous active-low reset
//  start               in   1                 frame request, sampled in IDLE only
//  bank_sel            in   clog2(BANKS)      coefficient bank, captured with start
//  frame_len           in   CNT_WIDTH         samples in frame, captured with start; 0 = treated as 1
//  abort               in   1                 terminate frame early
//  coeff_addr          out  clog2(BANKS*LENGTH) coefficient RAM address
//  coeff_rd_en         out  1                 RAM read strobe; data valid next cycle
//  coeff_rd_data       in   DATA_WIDTH        RAM read data (1-cycle latency)
//  s_valid/s_ready     in/out 1               sample input handshake
//  s_data              in   DATA_WIDTH        sample
//  load_coeff_flag     out  1                 to filter
//  load_data_flag      out  1                 to filter
//  stop_data_load_flag out  1                 to filter
//  coeff_set_flag      out  1                 to filter; tied 0
//  data_in, coeff_in   out  DATA_WIDTH        to filter
//  fir_result          in   3*DATA_WIDTH      filter data_out
//  m_valid/m_ready     out/in 1               result output handshake
//  m_data              out  3*DATA_WIDTH      filtered result
//  busy                out  1                 high in any state except IDLE
//  done                out  1                 one-cycle pulse on frame completion
// BEHAVIOUR
//  Reset (reset_n=0 at an edge)
//   - All outputs 0; state IDLE; counters 0; output register empty.
//   - Applies from any state. Mid-frame, the filter is left to its own state; next frame is only legal after a filter reset.
//  IDLE
//   - start=1: capture bank_sel and frame_len; move to COEF.
//  COEF (entry cycle T)
//   - load_coeff_flag=1 in cycle T only.
//   - coeff_rd_en=1, coeff_addr=bank*LENGTH+k in cycle T+k, k=0..LENGTH-1.
//   - coeff_in = coeff_rd_data registered-through: coefficient k appears in cycle T+1+k.
//   - coeff_in = 0 outside that window.
//   - In cycle T+LENGTH+1 move to STREAM.
//  STREAM
//   - s_ready = !pending && (!m_valid || m_ready).
//   - Handshake (s_valid&&s_ready): in that cycle drive load_data_flag=1 and data_in=s_data combinationally; set pending.
//   - Else load_data_flag=0, data_in=0.
//   - Accepted sample number frame_len (last): stop_data_load_flag=1 in the same cycle.
//   - RESULT_LAT cycles after the pulse: capture fir_result into m_data, m_valid=1, clear pending.
//   - m_valid clears on m_ready; a new capture in the same cycle reloads m_data (m_valid stays 1).
//   - Max throughput: one sample per RESULT_LAT+1 cycles.
//   - After the last capture, go to FLUSH.
//  abort in STREAM
//   - With no accept that cycle: issue load_data_flag=1, stop_data_load_flag=1, data_in=0; discard its result; go to FLUSH.
//   - Same cycle as an accept: that sample becomes the last (stop=1), its result is kept.
//   - abort in COEF: finish the coefficient load, then apply the abort in the first STREAM cycle.
//   - abort in IDLE/FLUSH: ignored.
//  FLUSH
//   - Wait 2 cycles while the filter clears, and until m_valid=0.
//   - Then done=1 for one cycle; return to IDLE.
//  Counter
//   - Accepted-sample counter wraps never; frame_len=0 behaves as 1.
// TESTING
//  1 Reset mid-STREAM -> next cycle all outputs 0, busy=0, s_ready=0.
//  2 bank_sel=1, LENGTH=20, start -> coeff_addr 20..39 in cycles T..T+19; coeff_in = RAM[20+k] at T+1+k; load_coeff_flag one cycle.
//  3 Coefficients {1,0..0}, frame_len=4, samples 5,-3,7,2, m_ready=1 -> m_data tracks filter output, 4 results, stop flag on sample 2, done once.
//  4 m_ready=0 for 10 cycles after the first result -> s_ready=0, m_data held, no load pulses; resumes on m_ready=1, no loss.
//  5 abort after 2 of 8 samples -> one zero-data pulse with load+stop, 2 results out, done, IDLE.
//  6 start with frame_len=0 -> exactly 1 sample accepted, stop asserted with it.

Source files
------------

// File: rtl/fir_stream_sequencer.sv
// rtl/fir_stream_sequencer.sv - frame sequencer for a single fir_convolution instance
// Loads one coefficient bank into the filter, then streams a frame of samples with valid/ready handshakes.
module fir_stream_sequencer #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 18,
  parameter int BANKS      = 2,
  parameter int CNT_WIDTH  = 16,
  parameter int RESULT_LAT = 1,
  localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int ADDR_W    = (BANKS * LENGTH > 1) ? $clog2(BANKS * LENGTH) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [BANK_W-1:0]       bank_sel,
  input  logic [CNT_WIDTH-1:0]    frame_len,
  input  logic                    abort,
  output logic [ADDR_W-1:0]       coeff_addr,
  output logic                    coeff_rd_en,
  input  logic [DATA_WIDTH-1:0]   coeff_rd_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    load_coeff_flag,
  output logic                    load_data_flag,
  output logic                    stop_data_load_flag,
  output logic                    coeff_set_flag,
  output logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   coeff_in,
  input  logic [3*DATA_WIDTH-1:0] fir_result,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [3*DATA_WIDTH-1:0] m_data,
  output logic                    busy,
  output logic                    done
);

  localparam int TAP_W = $clog2(LENGTH + 1);
  localparam int LAT_W = $clog2(RESULT_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_COEF, S_STREAM, S_FLUSH} state_t;

  state_t                  state, state_n;
  logic [ADDR_W-1:0]       base_q;
  logic [CNT_WIDTH-1:0]    len_q;
  logic [CNT_WIDTH-1:0]    acc_cnt;
  logic [TAP_W-1:0]        tap_cnt;
  logic [LAT_W-1:0]        lat_cnt;
  logic [1:0]              flush_cnt;
  logic                    rd_en_q;
  logic                    abort_pend;
  logic                    pending;
  logic                    keep_q;
  logic                    last_q;
  logic                    m_valid_q;
  logic [3*DATA_WIDTH-1:0] m_data_q;

  logic s_ready_int;
  logic accept;
  logic abort_eff;
  logic abort_pulse;
  logic pulse;
  logic is_last;
  logic stop_flag;
  logic capture;

  // Only one sample is ever in flight, so a single latency counter tracks the result.
  assign s_ready_int = (state == S_STREAM) && !pending && (!m_valid_q || m_ready);
  assign accept      = s_valid && s_ready_int;
  assign abort_eff   = abort || abort_pend;
  assign abort_pulse = (state == S_STREAM) && !pending && !accept && abort_eff;
  assign pulse       = accept || abort_pulse;
  assign is_last     = (acc_cnt == len_q - CNT_WIDTH'(1));
  assign stop_flag   = abort_pulse || (accept && (is_last || abort_eff));
  assign capture     = pending && (lat_cnt == LAT_W'(RESULT_LAT));

  assign coeff_rd_en     = (state == S_COEF) && (tap_cnt < TAP_W'(LENGTH));
  assign coeff_addr      = coeff_rd_en ? (base_q + ADDR_W'(tap_cnt)) : '0;
  assign load_coeff_flag = (state == S_COEF) && (tap_cnt == '0);
  assign coeff_in        = rd_en_q ? coeff_rd_data : '0;
  assign coeff_set_flag  = 1'b0;

  assign s_ready             = s_ready_int;
  assign load_data_flag      = pulse;
  assign stop_data_load_flag = stop_flag;
  assign data_in             = accept ? s_data : '0;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_n = S_COEF;
      S_COEF:   if (tap_cnt == TAP_W'(LENGTH)) state_n = S_STREAM;
      S_STREAM: if (capture && last_q) state_n = S_FLUSH;
      S_FLUSH: begin
        if (flush_cnt == 2'd2 && !m_valid_q) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      acc_cnt    <= '0;
      tap_cnt    <= '0;
      lat_cnt    <= '0;
      flush_cnt  <= '0;
      rd_en_q    <= 1'b0;
      abort_pend <= 1'b0;
      pending    <= 1'b0;
      keep_q     <= 1'b0;
      last_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state   <= state_n;
      rd_en_q <= coeff_rd_en;

      if (state == S_IDLE && start) begin
        base_q  <= ADDR_W'(int'(bank_sel) * LENGTH);
        len_q   <= (frame_len == '0) ? CNT_WIDTH'(1) : frame_len;
        acc_cnt <= '0;
        last_q  <= 1'b0;
      end

      if (state == S_COEF) tap_cnt <= tap_cnt + TAP_W'(1);
      else                 tap_cnt <= '0;

      // An abort seen during the coefficient load or while a result is pending waits for the next slot.
      if (pulse || state == S_IDLE || state == S_FLUSH) abort_pend <= 1'b0;
      else if (abort)                                   abort_pend <= 1'b1;

      if (pulse) begin
        pending <= 1'b1;
        lat_cnt <= LAT_W'(1);
        keep_q  <= accept;
        last_q  <= stop_flag;
        if (accept) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      end else if (capture) begin
        pending <= 1'b0;
      end else if (pending) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      if (capture && keep_q) begin
        m_data_q  <= fir_result;
        m_valid_q <= 1'b1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (state == S_FLUSH) begin
        if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
      end else begin
        flush_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb/tb_fir_stream_sequencer.sv - directed bench with coefficient RAM, filter model and result scoreboard
module tb_fir_stream_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [0:0]  bank_sel = '0;
  logic [15:0] frame_len = '0;
  logic        abort = 1'b0;
  logic [5:0]  coeff_addr;
  logic        coeff_rd_en;
  logic [17:0] coeff_rd_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [17:0] s_data = '0;
  logic        load_coeff_flag, load_data_flag, stop_data_load_flag, coeff_set_flag;
  logic [17:0] data_in, coeff_in;
  logic [53:0] fir_result = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [53:0] m_data;
  logic        busy, done;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0, stop_cnt = 0, res_cnt = 0, done_cnt = 0;
  logic [17:0] stop_data = '0;
  logic        stop_with_load = 1'b0;
  logic signed [63:0] sb[$];

  fir_stream_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .bank_sel(bank_sel),
    .frame_len(frame_len), .abort(abort), .coeff_addr(coeff_addr),
    .coeff_rd_en(coeff_rd_en), .coeff_rd_data(coeff_rd_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_coeff_flag(load_coeff_flag), .load_data_flag(load_data_flag),
    .stop_data_load_flag(stop_data_load_flag), .coeff_set_flag(coeff_set_flag),
    .data_in(data_in), .coeff_in(coeff_in), .fir_result(fir_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] ram_word(input int a);
    if (a < 20) return (a == 0) ? 18'd1 : 18'd0;
    return 18'(a + 100);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // RAM with one-cycle read latency; request sampled away from the edge
  logic       rd_en_s = 1'b0;
  logic [5:0] addr_s = '0;
  always @(negedge clock) begin
    rd_en_s = coeff_rd_en;
    addr_s  = coeff_addr;
  end
  always @(posedge clock) if (rd_en_s) coeff_rd_data <= ram_word(int'(addr_s));

  // Behavioural filter: result registered one cycle after a load pulse
  logic signed [17:0] taps [20];
  logic signed [17:0] hist [20];
  int  cidx = 0;
  bit  loading = 0;
  always @(negedge clock) begin
    longint acc;
    if (!reset_n) begin
      loading = 0;
      cidx = 0;
      fir_result = '0;
      for (int i = 0; i < 20; i++) hist[i] = '0;
    end else begin
      if (load_coeff_flag) begin
        loading = 1;
        cidx = 0;
      end else if (loading) begin
        taps[cidx] = coeff_in;
        cidx++;
        if (cidx == 20) loading = 0;
      end
      if (load_data_flag) begin
        for (int i = 19; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = data_in;
        acc = 0;
        for (int i = 0; i < 20; i++) acc += longint'(taps[i]) * longint'(hist[i]);
        fir_result = 54'(acc);
      end
    end
  end

  // Event counters and scoreboard pop on each output handshake
  always @(negedge clock) begin
    if (reset_n) begin
      if (load_data_flag) load_cnt++;
      if (stop_data_load_flag) begin
        stop_cnt++;
        stop_data = data_in;
        stop_with_load = load_data_flag;
      end
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
        res_cnt++;
        if (sb.size() == 0) check("unexpected_result", $signed(m_data), -1);
        else check("m_data", $signed(m_data), sb.pop_front());
      end
    end
  end

  task automatic start_frame(input logic b, input logic [15:0] len);
    @(posedge clock); #1;
    start = 1'b1; bank_sel = b; frame_len = len;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_sample(input int x, input logic signed [63:0] exp, output logic stop_seen);
    bit ok;
    ok = 0;
    stop_seen = 1'b0;
    s_data = 18'(x);
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (s_ready) begin ok = 1; break; end
    end
    check("s_ready_seen", ok, 1);
    if (ok) begin
      check("load_on_hs", load_data_flag, 1);
      check("data_in", $signed(data_in), x);
      stop_seen = stop_data_load_flag;
      sb.push_back(exp);
    end
    @(posedge clock); #1;
    s_valid = 1'b0;
    s_data = '0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
    check("done_seen", seen, 1);
    @(posedge clock); #1;
  endtask

  initial begin
    int l0, r0, d0, s0;
    logic st;
    int smp3 [4] = '{5, -3, 7, 2};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_done", done, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // bank 1 coefficient load window
    start_frame(1'b1, 16'd1);
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      check("coef_rd_en", coeff_rd_en, (k < 20));
      check("coef_load_flag", load_coeff_flag, (k == 0));
      if (k < 20) check("coef_addr", coeff_addr, 20 + k);
      check("coef_in", coeff_in, (k >= 1 && k <= 20) ? ram_word(20 + k - 1) : 18'd0);
    end
    @(posedge clock); #1;
    send_sample(3, 3 * 120, st);
    check("t2_stop", st, 1);
    wait_done();
    check("t2_idle", busy, 0);
    check("t2_results", res_cnt, 1);

    // identity filter, four samples
    r0 = res_cnt; d0 = done_cnt;
    start_frame(1'b0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      send_sample(smp3[i], smp3[i], st);
      check("t3_stop", st, (i == 3));
    end
    wait_done();
    check("t3_results", res_cnt - r0, 4);
    check("t3_done_once", done_cnt - d0, 1);

    // output backpressure
    r0 = res_cnt; l0 = load_cnt;
    start_frame(1'b0, 16'd3);
    send_sample(11, 11, st);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 18'd12;
    @(negedge clock);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("t4_m_valid", m_valid, 1);
      check("t4_m_data_held", m_data, 11);
      check("t4_s_ready", s_ready, 0);
      check("t4_no_load", load_data_flag, 0);
    end
    @(posedge clock); #1;
    m_ready = 1'b1;
    send_sample(12, 12, st);
    send_sample(13, 13, st);
    check("t4_last_stop", st, 1);
    wait_done();
    check("t4_results", res_cnt - r0, 3);
    check("t4_loads", load_cnt - l0, 3);

    // abort after two of eight samples
    r0 = res_cnt; l0 = load_cnt; s0 = stop_cnt; d0 = done_cnt;
    start_frame(1'b0, 16'd8);
    send_sample(21, 21, st);
    check("t5_stop0", st, 0);
    send_sample(22, 22, st);
    check("t5_stop1", st, 0);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    wait_done();
    check("t5_loads", load_cnt - l0, 3);
    check("t5_stops", stop_cnt - s0, 1);
    check("t5_stop_data", stop_data, 0);
    check("t5_stop_with_load", stop_with_load, 1);
    check("t5_results", res_cnt - r0, 2);
    check("t5_done", done_cnt - d0, 1);
    check("t5_idle", busy, 0);

    // frame_len of zero behaves as one
    r0 = res_cnt; l0 = load_cnt;
    start_frame(1'b0, 16'd0);
    send_sample(9, 9, st);
    check("t6_stop", st, 1);
    wait_done();
    s_valid = 1'b1;
    s_data = 18'd77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t6_idle_s_ready", s_ready, 0);
    end
    @(posedge clock); #1;
    s_valid = 1'b0;
    check("t6_loads", load_cnt - l0, 1);
    check("t6_results", res_cnt - r0, 1);
    check("sb_drained", sb.size(), 0);

    // reset in the middle of a stream
    start_frame(1'b0, 16'd5);
    send_sample(31, 31, st);
    @(posedge clock); @(posedge clock); #1;
    s_valid = 1'b1;
    s_data = 18'd32;
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("t1_busy", busy, 0);
    check("t1_s_ready", s_ready, 0);
    check("t1_m_valid", m_valid, 0);
    check("t1_m_data", m_data, 0);
    check("t1_load_data", load_data_flag, 0);
    check("t1_stop", stop_data_load_flag, 0);
    check("t1_load_coeff", load_coeff_flag, 0);
    check("t1_coeff_set", coeff_set_flag, 0);
    check("t1_rd_en", coeff_rd_en, 0);
    check("t1_addr", coeff_addr, 0);
    check("t1_coeff_in", coeff_in, 0);
    check("t1_data_in", data_in, 0);
    check("t1_done", done, 0);
    sb.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
